// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI scheduler slice.
package dac_spi_pkg;

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} sched_state_t;

    localparam int DAC_DW = 12;

endpackage

// File: rtl/dac_spi_scheduler_if.sv
// Word hand-off between the scheduler and the SPI DAC master (newd/data_in out, cs back).
interface dac_spi_scheduler_if
    import dac_spi_pkg::*;
#(
    parameter int DW = DAC_DW
);
    logic          spi_newd;
    logic [DW-1:0] spi_data;
    logic          spi_cs;

    modport master (output spi_newd, output spi_data, input spi_cs);
    modport slave  (input spi_newd, input spi_data, output spi_cs);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         pend,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 valid
);
    localparam int IW = $clog2(N);

    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        // Walk from the far end back to ptr so the nearest request is written last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (pend[IW'(idx)]) begin
                valid = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sync2.sv
// Two-flop synchroniser with a selectable reset level.
module sync2 #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dac_spi_scheduler.sv
// Buffers one sample per channel, grants round-robin and sequences newd/cs with the SPI DAC master.
module dac_spi_scheduler
    import dac_spi_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DW        = DAC_DW,
    parameter int START_TMO = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH*DW-1:0]      ch_data,
    output logic [NUM_CH-1:0]         ch_ack,
    output logic [NUM_CH-1:0]         ch_ovr,
    dac_spi_scheduler_if.master       spi,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      tmo_err
);
    localparam int IW = $clog2(NUM_CH);
    localparam int TW = $clog2(START_TMO + 1);

    logic [DW-1:0]     hold [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] in_service;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     arb_grant;
    logic              arb_valid;
    logic              cs_sync;
    logic [TW-1:0]     tmo_cnt;
    sched_state_t      state;
    logic              take;
    logic              tmo_hit;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .pend  (pend),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    sync2 #(.RST_VAL(1'b1)) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d   (spi.spi_cs),
        .q   (cs_sync)
    );

    assign take    = (state == S_IDLE) && arb_valid;
    assign tmo_hit = (state == S_START) && cs_sync && (tmo_cnt == TW'(START_TMO - 1));

    // The channel whose word is (or is about to be) on the bus never flags an overrun.
    always_comb begin
        in_service = '0;
        if (take)
            in_service[arb_grant] = 1'b1;
        else if (state != S_IDLE)
            in_service[grant_id] = 1'b1;
    end

    // Later assignments win: a same-cycle request re-arms pend over a grant clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend   <= '0;
            ch_ovr <= '0;
            for (int i = 0; i < NUM_CH; i++)
                hold[i] <= '0;
        end else begin
            if (take)
                pend[arb_grant] <= 1'b0;
            if (tmo_hit)
                pend[grant_id] <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_req[i]) begin
                    hold[i] <= ch_data[i*DW +: DW];
                    pend[i] <= 1'b1;
                    if (pend[i] && !in_service[i])
                        ch_ovr[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            grant_id     <= '0;
            spi.spi_newd <= 1'b0;
            spi.spi_data <= '0;
            busy         <= 1'b0;
            ch_ack       <= '0;
            tmo_err      <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            ch_ack  <= '0;
            tmo_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        grant_id     <= arb_grant;
                        spi.spi_data <= hold[arb_grant];
                        ptr          <= (arb_grant == IW'(NUM_CH - 1)) ? '0 : arb_grant + IW'(1);
                        spi.spi_newd <= 1'b1;
                        busy         <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= S_START;
                    end
                end
                // newd stays up until the master's cs (seen through the synchroniser) falls.
                S_START: begin
                    if (!cs_sync) begin
                        spi.spi_newd <= 1'b0;
                        state        <= S_BUSY;
                    end else if (tmo_hit) begin
                        spi.spi_newd <= 1'b0;
                        tmo_err      <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else if (tmo_cnt != TW'(START_TMO)) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_BUSY: begin
                    if (cs_sync) begin
                        ch_ack[grant_id] <= 1'b1;
                        state            <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
